// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Immediate generator with a one-entry output register and a one-entry
//   skid register. Each instruction accepted on the input handshake is
//   decoded combinationally. The result is registered together with its tag.
//   Results leave through a valid/ready output in strict arrival order.
//
// Optional feature (macro IMM_ILLEGAL_CHK_EN):
//   When the macro is defined, the block adds an out_err port. out_err is
//   registered alongside each entry and flags:
//     - format 111, and
//     - format 101 with instr[25]=1 when XLEN=32.
//
// Parameters
//   XLEN   immediate width (32 or 64)
//   TAG_W  sideband tag width
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_instr            raw 32-bit instruction
//   in_immsrc           format select (I,S,B,U,J,shamt,zimm,zero)
//   in_tag              sideband tag carried with the entry
//   flush               drop every held entry on the next edge
//   out_valid/out_ready output handshake
//   out_imm, out_tag    extended immediate and its tag
//   out_err             illegal-format flag (IMM_ILLEGAL_CHK_EN only)
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_immsrc,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag
`ifdef IMM_ILLEGAL_CHK_EN
    ,
    output logic             out_err
`endif
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
`ifdef IMM_ILLEGAL_CHK_EN
        logic             err;
`endif
    } entry_t;

    entry_t      in_e, out_q, skid_q;
    logic        out_v, skid_v;
    logic        in_fire, out_fire;
    logic signed [31:0] sx32;
    logic [XLEN-1:0]    imm_d;

    // The sign-extended formats are assembled as a signed 32-bit value.
    // That value is then widened, so XLEN=32 never needs a zero-width
    // replication.
    always_comb begin
        sx32  = '0;
        imm_d = '0;
        case (in_immsrc)
            3'b000: sx32 = {{20{in_instr[31]}}, in_instr[31:20]};
            3'b001: sx32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            3'b010: sx32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                            in_instr[11:8], 1'b0};
            3'b011: sx32 = {in_instr[31:12], 12'b0};
            3'b100: sx32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                            in_instr[30:21], 1'b0};
            3'b101: imm_d = (XLEN == 64) ? XLEN'(in_instr[25:20])
                                         : XLEN'(in_instr[24:20]);
            3'b110: imm_d = XLEN'(in_instr[19:15]);
            default: ;
        endcase
        if (in_immsrc <= 3'b100)
            imm_d = XLEN'(sx32);
    end

    always_comb begin
        in_e     = '0;
        in_e.imm = imm_d;
        in_e.tag = in_tag;
`ifdef IMM_ILLEGAL_CHK_EN
        in_e.err = (in_immsrc == 3'b111) ||
                   ((XLEN == 32) && (in_immsrc == 3'b101) && in_instr[25]);
`endif
    end

    // in_ready depends only on registered state. out_ready has no
    // combinational path to it.
    assign in_ready = !skid_v;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_v && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            out_q  <= '0;
            skid_q <= '0;
        end else if (flush) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
        end else if (out_fire || !out_v) begin
            // The output slot is free this edge. The older skid entry has
            // priority. in_ready is low whenever the skid is full, so no
            // new entry can arrive in that case.
            if (skid_v) begin
                out_q  <= skid_q;
                out_v  <= 1'b1;
                skid_v <= 1'b0;
            end else if (in_fire) begin
                out_q <= in_e;
                out_v <= 1'b1;
            end else begin
                out_v <= 1'b0;
            end
        end else if (in_fire) begin
            // The output is stalled, so the new entry parks in the skid.
            skid_q <= in_e;
            skid_v <= 1'b1;
        end
    end

    assign out_valid = out_v;
    assign out_imm   = out_q.imm;
    assign out_tag   = out_q.tag;
`ifdef IMM_ILLEGAL_CHK_EN
    assign out_err   = out_q.err;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_immsrc;
    logic [63:0] in_tag;
    logic        flush;
    logic        out_ready;

    logic        ir64, ov64, ir32, ov32;
    logic [63:0] imm64, tag64, tag32;
    logic [31:0] imm32;
`ifdef IMM_ILLEGAL_CHK_EN
    logic        err64, err32;
`endif

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .TAG_W(64)) d64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir64),
        .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
        .flush(flush), .out_valid(ov64), .out_ready(out_ready),
        .out_imm(imm64), .out_tag(tag64)
`ifdef IMM_ILLEGAL_CHK_EN
        , .out_err(err64)
`endif
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(64)) d32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32),
        .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
        .flush(flush), .out_valid(ov32), .out_ready(out_ready),
        .out_imm(imm32), .out_tag(tag32)
`ifdef IMM_ILLEGAL_CHK_EN
        , .out_err(err32)
`endif
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference decode, built from the architectural immediate rules using
    // plain 64-bit arithmetic.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                            input int xlen);
        longint sx, a;
        logic [63:0] u, r;
        sx = longint'($signed(ins));
        u  = {32'b0, ins};
        a  = sx >>> 31;             // all ones when ins[31] is set
        case (src)
            3'd0: r = sx >>> 20;
            3'd1: r = (a << 12) | (((u >> 25) & 64'h7F) << 5) | ((u >> 7) & 64'h1F);
            3'd2: r = (a << 12) | (((u >> 7) & 64'h1) << 11) |
                      (((u >> 25) & 64'h3F) << 5) | (((u >> 8) & 64'hF) << 1);
            3'd3: r = sx & ~64'hFFF;
            3'd4: r = (a << 20) | (((u >> 12) & 64'hFF) << 12) |
                      (((u >> 20) & 64'h1) << 11) | (((u >> 21) & 64'h3FF) << 1);
            3'd5: r = (xlen == 64) ? ((u >> 20) & 64'h3F) : ((u >> 20) & 64'h1F);
            3'd6: r = (u >> 15) & 64'h1F;
            default: r = 64'h0;
        endcase
        if (xlen == 32) r = r & 64'hFFFF_FFFF;
        return r;
    endfunction

    function automatic logic ref_err(input logic [31:0] ins, input logic [2:0] src,
                                     input int xlen);
        return (src == 3'd7) || (xlen == 32 && src == 3'd5 && ins[25]);
    endfunction

    // Model: a FIFO of accepted entries with capacity two.
    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [63:0] tag;
    } ent_t;
    ent_t q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) q.delete();
        else if (flush) q.delete();
        else begin : upd
            bit rdy, ov;
            rdy = (q.size() < 2);
            ov  = (q.size() > 0);
            if (ov && out_ready) void'(q.pop_front());
            if (in_valid && rdy) q.push_back('{in_instr, in_immsrc, in_tag});
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("m_in_ready64", {63'b0, ir64}, {63'b0, q.size() < 2});
            chk("m_in_ready32", {63'b0, ir32}, {63'b0, q.size() < 2});
            chk("m_out_valid64", {63'b0, ov64}, {63'b0, q.size() > 0});
            chk("m_out_valid32", {63'b0, ov32}, {63'b0, q.size() > 0});
            if (q.size() > 0) begin
                chk("m_imm64", imm64, ref_imm(q[0].instr, q[0].src, 64));
                chk("m_imm32", {32'b0, imm32}, ref_imm(q[0].instr, q[0].src, 32));
                chk("m_tag64", tag64, q[0].tag);
                chk("m_tag32", tag32, q[0].tag);
`ifdef IMM_ILLEGAL_CHK_EN
                chk("m_err64", {63'b0, err64}, {63'b0, ref_err(q[0].instr, q[0].src, 64)});
                chk("m_err32", {63'b0, err32}, {63'b0, ref_err(q[0].instr, q[0].src, 32)});
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src,
                         input logic [63:0] tag);
        in_valid  = v;
        in_instr  = ins;
        in_immsrc = src;
        in_tag    = tag;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_immsrc = '0;
        in_tag = '0; flush = 1'b0; out_ready = 1'b0;

        // Pin the reference decode with hand-computed values.
        chk("pin_I",   ref_imm(32'hFFF00093, 3'd0, 64), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("pin_B",   ref_imm(32'h80000063, 3'd2, 64), 64'hFFFF_FFFF_FFFF_F000);
        chk("pin_J",   ref_imm(32'h0010006F, 3'd4, 64), 64'h800);
        chk("pin_U32", ref_imm(32'hABCDE037, 3'd3, 32), 64'hABCDE000);
        chk("pin_S",   ref_imm(32'hFE000FA3, 3'd1, 64), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("pin_sh32",ref_imm(32'h03300013, 3'd5, 32), 64'h13);

        repeat (3) step();
        chk("rst_ov64",  {63'b0, ov64}, 64'h0);
        chk("rst_ov32",  {63'b0, ov32}, 64'h0);
        chk("rst_imm64", imm64, 64'h0);
        chk("rst_tag64", tag64, 64'h0);
        chk("rst_imm32", {32'b0, imm32}, 64'h0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        #1;
        chk("rst_in_ready", {63'b0, ir64}, 64'h1);

        // I-type, one-cycle latency
        out_ready = 1'b1;
        drive(1'b1, 32'hFFF00093, 3'd0, 64'h1000);
        step();
        drive(1'b0, 32'h0, 3'd0, 64'h0);
        chk("i_ov",    {63'b0, ov64}, 64'h1);
        chk("i_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("i_imm32", {32'b0, imm32}, 64'hFFFF_FFFF);
        chk("i_tag",   tag64, 64'h1000);

        // B-type, J-type
        drive(1'b1, 32'h80000063, 3'd2, 64'h2000);
        step();
        chk("b_imm64", imm64, 64'hFFFF_FFFF_FFFF_F000);
        drive(1'b1, 32'h0010006F, 3'd4, 64'h3000);
        step();
        chk("j_imm64", imm64, 64'h800);
        drive(1'b0, 32'h0, 3'd0, 64'h0);
        step();

        // Stall with three back-to-back offers
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 3'd0, 64'hA1);
        step();
        drive(1'b1, 32'h00200093, 3'd0, 64'hA2);
        step();
        drive(1'b1, 32'h00300093, 3'd0, 64'hA3);
        chk("stall_in_ready", {63'b0, ir64}, 64'h0);
        chk("stall_tag_a",    tag64, 64'hA1);
        step();
        chk("stall_hold_tag", tag64, 64'hA1);
        chk("stall_hold_imm", imm64, 64'h1);
        out_ready = 1'b1;
        step();
        chk("drain_tag_b",    tag64, 64'hA2);
        chk("drain_in_ready", {63'b0, ir64}, 64'h1);
        step();
        drive(1'b0, 32'h0, 3'd0, 64'h0);
        chk("drain_tag_c", tag64, 64'hA3);
        step();
        chk("drain_empty", {63'b0, ov64}, 64'h0);

        // Flush with both slots full and a concurrent offer
        out_ready = 1'b0;
        drive(1'b1, 32'h00500093, 3'd0, 64'hB1);
        step();
        drive(1'b1, 32'h00600093, 3'd0, 64'hB2);
        step();
        drive(1'b1, 32'h00700093, 3'd0, 64'hB3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 64'h0);
        chk("flush_ov",       {63'b0, ov64}, 64'h0);
        chk("flush_in_ready", {63'b0, ir64}, 64'h1);
        out_ready = 1'b1;
        step();
        chk("flush_no_emit", {63'b0, ov64}, 64'h0);

        // Asynchronous reset while holding an entry
        out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 3'd0, 64'hC1);
        step();
        drive(1'b0, 32'h0, 3'd0, 64'h0);
        chk("areset_pre_ov", {63'b0, ov64}, 64'h1);
        rst_n = 1'b0;
        #1;
        chk("areset_ov",  {63'b0, ov64}, 64'h0);
        chk("areset_imm", imm64, 64'h0);
        chk("areset_tag", tag64, 64'h0);
        step();
        rst_n = 1'b1;
        step();

`ifdef IMM_ILLEGAL_CHK_EN
        out_ready = 1'b1;
        drive(1'b1, 32'h03300013, 3'd5, 64'hD1);
        step();
        chk("err_sh_imm32", {32'b0, imm32}, 64'h13);
        chk("err_sh_err32", {63'b0, err32}, 64'h1);
        chk("err_sh_imm64", imm64, 64'h33);
        chk("err_sh_err64", {63'b0, err64}, 64'h0);
        drive(1'b1, 32'h000F8073, 3'd6, 64'hD2);
        step();
        chk("zimm_imm32", {32'b0, imm32}, 64'h1F);
        chk("zimm_err32", {63'b0, err32}, 64'h0);
        drive(1'b1, 32'h12345678, 3'd7, 64'hD3);
        step();
        chk("f7_err64", {63'b0, err64}, 64'h1);
        chk("f7_imm64", imm64, 64'h0);
        drive(1'b0, 32'h0, 3'd0, 64'h0);
        step();
`endif

        // Randomized traffic, checked each cycle against the model
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom % 4) != 0, $urandom, 3'($urandom_range(0, 7)),
                  {$urandom, $urandom});
            out_ready = (i % 300 < 150) ? (($urandom % 4) != 0) : (($urandom % 3) == 0);
            flush     = (($urandom % 40) == 0);
            step();
        end
        drive(1'b0, 32'h0, 3'd0, 64'h0);
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 64: immediate width; legal values 32 and 64.
REQ-002 Parameter TAG_W, default 64: width of the sideband tag (PC) carried with each instruction.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  instruction offered.
REQ-006 in_ready  output  1  block can accept an instruction.
REQ-007 in_instr  input  32  raw instruction word.
REQ-008 in_immsrc  input  3  immediate format select.
REQ-009 in_tag  input  TAG_W  sideband tag.
REQ-010 flush  input  1  discard all held entries.
REQ-011 out_valid  output  1  extended immediate available.
REQ-012 out_ready  input  1  consumer accepts.
REQ-013 out_imm  output  XLEN  extended immediate.
REQ-014 out_tag  output  TAG_W  tag matching out_imm.
REQ-015 out_err  output  1  illegal-format flag (present only with IMM_ILLEGAL_CHK_EN).

Function
REQ-016 Format decode by in_immsrc: 000 I, 001 S, 010 B (bit0=0), 011 U (low 12 bits=0), 100 J (bit0=0), all sign-extended from instr[31] to XLEN.
REQ-017 Format 101 (shift amount): zero-extended instr[25:20] when XLEN=64, instr[24:20] when XLEN=32.
REQ-018 Format 110 (CSR zimm): zero-extended instr[19:15].
REQ-019 Format 111: out_imm all zeros.
REQ-020 For XLEN=32, U-type is instr[31:12],12'b0 with no extension bits.
REQ-021 Decode is computed combinationally from inputs and registered; latency is exactly 1 cycle from input handshake to out_valid when the output register is empty.
REQ-022 Storage: one output register plus one skid register; in_ready is high whenever the skid register is empty, with no combinational path from out_ready.
REQ-023 Input handshake when in_valid && in_ready; output handshake when out_valid && out_ready.
REQ-024 Accepted entry goes to the output register if it is empty or is being drained that cycle, otherwise to the skid register.
REQ-025 When the output drains and the skid is full, the skid entry moves to the output register on the same edge.
REQ-026 Order is strictly preserved; no entry is dropped or duplicated without flush.
REQ-027 flush clears both valid bits on the next edge, overrides any concurrent input or output handshake, and in_ready is high the following cycle.
REQ-028 out_imm, out_tag, and out_err hold stable while out_valid && !out_ready.
REQ-029 Sustained throughput is one entry per cycle while out_ready stays high.

Reset
REQ-030 While rst_n is low: out_valid=0, skid valid=0, out_imm=0, out_tag=0, and out_err=0; in_ready is high once rst_n is released.
REQ-031 Reset asserted mid-transfer discards all held entries; no output handshake completes in that cycle.

Configuration
REQ-032 With macro IMM_ILLEGAL_CHK_EN defined, out_err is registered with its entry: high for format 111, or for XLEN=32 and format 101 with instr[25]=1.
REQ-033 With the macro undefined, port out_err and its storage are absent and behaviour is otherwise identical.

Verification
REQ-034 XLEN=64, I-type instr 0xFFF00093, immsrc 000, out_ready=1 -> one cycle later out_valid=1, out_imm=0xFFFFFFFFFFFFFFFF.
REQ-035 B-type instr 0x8000_0063, immsrc 010 -> out_imm=0xFFFFFFFFFFFFF000; J-type 0x0010_006F, immsrc 100 -> out_imm=0x800.
REQ-036 out_ready=0 with 3 back-to-back valid inputs -> first two held (output+skid), in_ready=0 from cycle 3; out_ready=1 -> entries emerge in order, tags intact.
REQ-037 Output and skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input not emitted.
REQ-038 XLEN=32, macro defined, immsrc 101 with instr[25]=1 -> out_err=1, out_imm=instr[24:20] zero-extended; immsrc 110 with instr[19:15]=0x1F -> out_imm=0x1F, out_err=0.
REQ-039 rst_n pulsed low while out_valid=1 -> out_valid=0 immediately (asynchronously), all outputs 0.
